one_port_ram_ctrl: RTL and testbench

ONE_PORT_RAM_CTRL -- requirements
Module: one_port_ram_ctrl

---
 rtl/ram_pkg.sv | 14 +
 rtl/one_port_ram_ctrl_if.sv | 28 ++
 rtl/ram_be_array.sv | 45 ++++
 rtl/one_port_ram_ctrl.sv | 148 ++++++++++++++
 tb/tb_one_port_ram_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared encodings for the single-port RAM controller and its storage array.
// Holds the read-during-write policy codes and the clear FSM state encoding.
// No logic here; nothing to stall.
package ram_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/one_port_ram_ctrl_if.sv
// Access bus between a requester and one_port_ram_ctrl.
// Carries request fields, clear strobe, read data, rvalid and busy.
// Requests are dropped, not stalled, while busy is high.
interface one_port_ram_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                      en;
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     din;
    logic                      clr;
    logic [DATA_WIDTH-1:0]     dout;
    logic                      rvalid;
    logic                      busy;

    modport master (
        output en, we, be, addr, din, clr,
        input  dout, rvalid, busy
    );

    modport slave (
        input  en, we, be, addr, din, clr,
        output dout, rvalid, busy
    );

endinterface

// File: rtl/ram_be_array.sv
// Storage array with byte-enable writes and a combinational read port.
// Read data is combinational from addr_i; writes land on the rising edge.
// No backpressure; every we_i cycle writes.
module ram_be_array
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int WR_MODE    = READ_FIRST
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NBYTE = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] old_w;
    logic [DATA_WIDTH-1:0] merged_w;

    always_comb begin
        old_w    = mem_q[addr_i];
        merged_w = old_w;
        for (int i = 0; i < NBYTE; i++) begin
            if (be_i[i]) begin
                merged_w[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

    // WRITE_FIRST forwards the merged word so the reader sees what is being stored.
    assign rdata_o = ((WR_MODE == WRITE_FIRST) && we_i) ? merged_w : old_w;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= merged_w;
        end
    end

endmodule

// File: rtl/one_port_ram_ctrl.sv
// Single-port RAM controller: access gating, zero-fill clear FSM, read pipeline.
// Response (rvalid/dout) RD_LATENCY cycles after acceptance, one per accepted access.
// Accepts one access per cycle; accesses arriving while busy are dropped.
module one_port_ram_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int RD_LATENCY     = 1,
    parameter int WR_MODE        = READ_FIRST,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    one_port_ram_ctrl_if.slave bus
);

    localparam int                    NBYTE     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic                  INIT_BUSY = (CLEAR_ON_RESET != 0);

    clr_state_e            state_q;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  acc;

    logic                  arr_we;
    logic [NBYTE-1:0]      arr_be;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign acc      = bus.en & ~busy_q;
    assign bus.busy = busy_q;

    // busy_q high in IDLE only after reset: that first edge already writes address 0,
    // so the post-reset fill and a clr-started fill both last exactly DEPTH cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= INIT_BUSY;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (busy_q) begin
                        state_q <= CLEAR;
                        cnt_q   <= cnt_q + 1'b1;
                    end else if (bus.clr) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        if (busy_q) begin
            arr_we    = 1'b1;
            arr_be    = '1;
            arr_addr  = cnt_q;
            arr_wdata = '0;
        end else begin
            arr_we    = acc & bus.we;
            arr_be    = bus.be;
            arr_addr  = bus.addr;
            arr_wdata = bus.din;
        end
    end

    ram_be_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WR_MODE    (WR_MODE)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .be_i    (arr_be),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign bus.rvalid = acc;
            assign bus.dout   = reset_n ? arr_rdata : '0;
        end else if (RD_LATENCY == 1) begin : g_lat1
            logic                  vld_q;
            logic [DATA_WIDTH-1:0] dat_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_q <= 1'b0;
                    dat_q <= '0;
                end else begin
                    vld_q <= acc;
                    if (acc) begin
                        dat_q <= arr_rdata;
                    end
                end
            end

            assign bus.rvalid = vld_q;
            assign bus.dout   = dat_q;
        end else begin : g_lat2
            logic                  vld1_q;
            logic                  vld2_q;
            logic [DATA_WIDTH-1:0] dat1_q;
            logic [DATA_WIDTH-1:0] dat2_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld1_q <= 1'b0;
                    vld2_q <= 1'b0;
                    dat1_q <= '0;
                    dat2_q <= '0;
                end else begin
                    vld1_q <= acc;
                    vld2_q <= vld1_q;
                    if (acc) begin
                        dat1_q <= arr_rdata;
                    end
                    if (vld1_q) begin
                        dat2_q <= dat1_q;
                    end
                end
            end

            assign bus.rvalid = vld2_q;
            assign bus.dout   = dat2_q;
        end
    endgenerate

endmodule

// File: tb/tb_one_port_ram_ctrl.sv
// Drives identical random/directed traffic into three controller variants
// (latency 0/1/2, mixed read-during-write policy) and scores them against one memory model.
module tb_one_port_ram_ctrl;
    import ram_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 2 ** AW;

    typedef struct {
        int          due;
        logic [15:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        t_rst_n;
    logic        t_en, t_we, t_clr;
    logic [1:0]  t_be;
    logic [3:0]  t_addr;
    logic [15:0] t_din;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          busy_left;
    logic [15:0] mem_m [DEPTH];
    exp_t        q1[$];
    exp_t        q2[$];
    logic [15:0] last1, last2;

    always #5 clk = ~clk;

    one_port_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    one_port_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
    one_port_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

    assign if0.en = t_en;   assign if1.en = t_en;   assign if2.en = t_en;
    assign if0.we = t_we;   assign if1.we = t_we;   assign if2.we = t_we;
    assign if0.be = t_be;   assign if1.be = t_be;   assign if2.be = t_be;
    assign if0.addr = t_addr; assign if1.addr = t_addr; assign if2.addr = t_addr;
    assign if0.din = t_din; assign if1.din = t_din; assign if2.din = t_din;
    assign if0.clr = t_clr; assign if1.clr = t_clr; assign if2.clr = t_clr;

    one_port_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(0),
                        .WR_MODE(WRITE_FIRST), .CLEAR_ON_RESET(1))
        u_d0 (.clk(clk), .reset_n(t_rst_n), .bus(if0));
    one_port_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1),
                        .WR_MODE(READ_FIRST), .CLEAR_ON_RESET(1))
        u_d1 (.clk(clk), .reset_n(t_rst_n), .bus(if1));
    one_port_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2),
                        .WR_MODE(WRITE_FIRST), .CLEAR_ON_RESET(1))
        u_d2 (.clk(clk), .reset_n(t_rst_n), .bus(if2));

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] b);
        merge = old;
        if (b[0]) merge[7:0]  = nw[7:0];
        if (b[1]) merge[15:8] = nw[15:8];
    endfunction

    // Response word for the access currently on the bus, from the model memory.
    function automatic logic [15:0] resp(input bit write_first);
        if (t_we && write_first) return merge(mem_m[t_addr], t_din, t_be);
        return mem_m[t_addr];
    endfunction

    function automatic void model_reset();
        q1.delete();
        q2.delete();
        last1     = '0;
        last2     = '0;
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endfunction

    function automatic void model_edge();
        cyc++;
        if (!t_rst_n) return;
        if (busy_left > 0) begin
            busy_left--;
            return;
        end
        if (t_en) begin
            q1.push_back('{due: cyc,     dat: resp(1'b0)});
            q2.push_back('{due: cyc + 1, dat: resp(1'b1)});
            if (t_we) mem_m[t_addr] = merge(mem_m[t_addr], t_din, t_be);
        end
        if (t_clr) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            busy_left = DEPTH;
        end
    endfunction

    task automatic check_comb();
        logic ev;
        if (!t_rst_n) begin
            check_eq("rst_rvalid0", {31'd0, if0.rvalid}, 32'd0);
            check_eq("rst_dout0", {16'd0, if0.dout}, 32'd0);
        end else begin
            ev = t_en && (busy_left == 0);
            check_eq("rvalid0", {31'd0, if0.rvalid}, {31'd0, ev});
            if (ev) check_eq("dout0", {16'd0, if0.dout}, {16'd0, resp(1'b1)});
        end
    endtask

    task automatic check_regs();
        logic eb, ev1, ev2;
        eb = (busy_left > 0);
        check_eq("busy0", {31'd0, if0.busy}, {31'd0, eb});
        check_eq("busy1", {31'd0, if1.busy}, {31'd0, eb});
        check_eq("busy2", {31'd0, if2.busy}, {31'd0, eb});
        ev1 = (q1.size() > 0) && (q1[0].due == cyc);
        if (ev1) begin
            last1 = q1[0].dat;
            void'(q1.pop_front());
        end
        ev2 = (q2.size() > 0) && (q2[0].due == cyc);
        if (ev2) begin
            last2 = q2[0].dat;
            void'(q2.pop_front());
        end
        check_eq("rvalid1", {31'd0, if1.rvalid}, {31'd0, ev1});
        check_eq("dout1", {16'd0, if1.dout}, {16'd0, last1});
        check_eq("rvalid2", {31'd0, if2.rvalid}, {31'd0, ev2});
        check_eq("dout2", {16'd0, if2.dout}, {16'd0, last2});
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic r, input logic e, input logic w, input logic [1:0] b,
                        input logic [3:0] a, input logic [15:0] d, input logic c);
        if (!r && t_rst_n) model_reset();
        t_rst_n = r;
        t_en    = e;
        t_we    = w;
        t_be    = b;
        t_addr  = a;
        t_din   = d;
        t_clr   = c;
        #1;
        check_comb();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic rand_step(input logic r, input int clr_one_in);
        logic c;
        c = (clr_one_in > 0) ? ($urandom_range(clr_one_in - 1) == 0) : 1'b0;
        step(r, ($urandom_range(3) != 0), 1'($urandom), 2'($urandom),
             4'($urandom), 16'($urandom), c);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 2'b00, 4'(i), 16'h0, 1'b0);
    endtask

    initial begin
        t_rst_n = 1'b0;
        t_en = 1'b0; t_we = 1'b0; t_clr = 1'b0;
        t_be = '0; t_addr = '0; t_din = '0;
        model_reset();
        @(negedge clk);

        // Reset, then post-reset fill with accesses hammering the busy window.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) rand_step(1'b1, 0);
        read_all();

        // Partial byte-enable overwrite, then read back.
        step(1'b1, 1'b1, 1'b1, 2'b11, 4'd3, 16'hABCD, 1'b0);
        step(1'b1, 1'b1, 1'b1, 2'b10, 4'd3, 16'h1200, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0000, 1'b0);

        // Read-during-write policy on a low-byte write.
        step(1'b1, 1'b1, 1'b1, 2'b11, 4'd5, 16'h1111, 1'b0);
        step(1'b1, 1'b1, 1'b1, 2'b01, 4'd5, 16'h2222, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b0);

        // Alternate write/read to one address every cycle.
        for (int i = 0; i < 24; i++)
            step(1'b1, 1'b1, ((i % 2) == 0), 2'($urandom), 4'd6, 16'($urandom), 1'b0);

        // Clear together with a read of prefilled data, then traffic while busy.
        step(1'b1, 1'b1, 1'b1, 2'b11, 4'd9, 16'h5A5A, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'b00, 4'd9, 16'h0000, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) rand_step(1'b1, 4);
        read_all();

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) rand_step(1'b1, 64);
        while (busy_left > 0) rand_step(1'b1, 0);

        // Reset asserted partway through a clear of a populated array.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b1, 1'b1, 2'b11, 4'(i), 16'($urandom) | 16'h0101, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 1'b1);
        for (int i = 0; i < 8; i++) rand_step(1'b1, 0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) rand_step(1'b1, 0);
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
